// File: rtl/scp_run_ctrl.sv
// Reset/run sequencer and run monitor for the single-cycle core: holds it in reset, runs it
// for a bounded number of cycles, and reports halt/timeout statistics. Optional: SCP_RUN_SIG_EN.
module scp_run_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              CNT_W      = 16,
    parameter int              RST_CYCLES = 4,
    parameter int              MAX_CYCLES = 200,
    parameter logic [XLEN-1:0] HALT_INSTR = 32'h0000006F
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             retire_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    output logic             core_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [XLEN-1:0]  halt_pc_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [XLEN-1:0]  sig_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    localparam int               RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [RC_W-1:0]  r_rstCnt;
    logic             r_coreRstN;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [XLEN-1:0]  r_haltPc;
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_instrCnt;
    logic             w_halt;
    logic             w_budgetOut;
    logic             w_launch;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_nextState = r_state;
        w_halt      = retire_i && (instr_i == HALT_INSTR);
        w_budgetOut = (r_cycleCnt == CYC_LAST);
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_nextState = S_RESET;
                    w_launch    = 1'b1;
                end
            end
            S_RESET: begin
                if (r_rstCnt == '0) w_nextState = S_RUN;
            end
            S_RUN: begin
                if (w_halt || w_budgetOut) w_nextState = S_DONE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_rstCnt   <= '0;
            r_coreRstN <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_haltPc   <= '0;
            r_cycleCnt <= '0;
            r_instrCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_coreRstN <= (w_nextState == S_RUN);
            r_busy     <= (w_nextState == S_RESET) || (w_nextState == S_RUN);
            r_done     <= (w_nextState == S_DONE);
            if (w_launch) begin
                r_rstCnt   <= RC_INIT;
                r_timeout  <= 1'b0;
                r_haltPc   <= '0;
                r_cycleCnt <= '0;
                r_instrCnt <= '0;
            end else if (r_state == S_RESET) begin
                if (r_rstCnt != '0) r_rstCnt <= r_rstCnt - RC_W'(1);
            end else if (r_state == S_RUN) begin
                r_cycleCnt <= satInc(r_cycleCnt);
                if (retire_i) r_instrCnt <= satInc(r_instrCnt);
                if (w_halt) begin
                    r_haltPc  <= pc_i;
                    r_timeout <= 1'b0;
                end else if (w_budgetOut) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef SCP_RUN_SIG_EN
    logic [XLEN-1:0] r_sig;

    // Rotate-left-and-xor fold of every PC retired during RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sig <= '0;
        end else if (w_launch) begin
            r_sig <= '0;
        end else if ((r_state == S_RUN) && retire_i) begin
            r_sig <= {r_sig[XLEN-2:0], r_sig[XLEN-1]} ^ pc_i;
        end
    end

    assign sig_o = r_sig;
`else
    assign sig_o = '0;
`endif

    assign core_rst_n_o = r_coreRstN;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
    assign halt_pc_o    = r_haltPc;
    assign cycle_cnt_o  = r_cycleCnt;
    assign instr_cnt_o  = r_instrCnt;

endmodule
